// File: rtl/bitplane_pkg.sv
// Shared types and defaults for the bitplane sequencer.
// Plane p is shown for base << p cycles (binary-coded modulation).
package bitplane_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int DEF_DEPTH       = 4;
    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_BASE_TICKS  = 64;
    localparam int DEF_BLANK_TICKS = 4;

    function automatic int show_ticks(input int base, input int p);
        return base << p;
    endfunction

endpackage

// File: rtl/bitplane_select.sv
// Combinational plane extractor: bit j of the result is field j's bit 'plane'.
// Zero latency; no flow control. Out-of-range planes yield all zeros.
module bitplane_select
    import bitplane_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [3*CHANNELS*DEPTH-1:0] in_data,
    input  logic [PW-1:0]               plane,
    output logic [3*CHANNELS-1:0]       bits
);

    always_comb begin
        bits = '0;
        for (int j = 0; j < 3*CHANNELS; j++) begin
            if (int'(plane) < DEPTH) begin
                bits[j] = in_data[j*DEPTH + int'(plane)];
            end
        end
    end

endmodule

// File: rtl/bitplane_sequencer.sv
// Shows each bitplane of a captured word for BASE_TICKS<<p cycles, blanking between planes.
// Accepts a word only in IDLE (in_ready); registered outputs; one word per frame.
module bitplane_sequencer
    import bitplane_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int BASE_TICKS  = DEF_BASE_TICKS,
    parameter int BLANK_TICKS = DEF_BLANK_TICKS
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clear,
    input  logic [3*CHANNELS*DEPTH-1:0]             in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [3*CHANNELS-1:0]                   rgb_out,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] plane,
    output logic                                    oe_n,
    output logic                                    frame_done
);

    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LONGEST = show_ticks(BASE_TICKS, DEPTH - 1);
    localparam int MAXT    = (LONGEST > BLANK_TICKS) ? LONGEST : BLANK_TICKS;
    localparam int CW      = $clog2(MAXT + 1);

    state_t                        state, state_nxt;
    logic [CW-1:0]                 cnt, cnt_nxt;
    logic [3*CHANNELS*DEPTH-1:0]   word, word_nxt;
    logic                          last, last_nxt;
    logic [3*CHANNELS-1:0]         rgb_nxt, sel_bits;
    logic [PW-1:0]                 plane_nxt, sel_plane;
    logic [3*CHANNELS*DEPTH-1:0]   sel_data;
    logic                          oe_n_nxt, fd_nxt, show_end;

    assign in_ready = (state == IDLE) && !clear;
    assign show_end = (cnt == CW'(show_ticks(BASE_TICKS, int'(plane)) - 1));

    // In IDLE the extractor looks at the incoming word's plane 0; otherwise at the next plane.
    always_comb begin
        sel_data  = word;
        sel_plane = plane + PW'(1);
        if (state == IDLE) begin
            sel_data  = in_data;
            sel_plane = '0;
        end
    end

    bitplane_select #(
        .DEPTH    (DEPTH),
        .CHANNELS (CHANNELS),
        .PW       (PW)
    ) u_select (
        .in_data (sel_data),
        .plane   (sel_plane),
        .bits    (sel_bits)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        last_nxt  = last;
        rgb_nxt   = rgb_out;
        plane_nxt = plane;
        oe_n_nxt  = oe_n;
        fd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                oe_n_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    word_nxt  = in_data;
                    rgb_nxt   = sel_bits;
                    plane_nxt = '0;
                    oe_n_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (show_end) begin
                    state_nxt = BLANK;
                    oe_n_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    last_nxt  = (plane == PW'(DEPTH - 1));
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            BLANK: begin
                cnt_nxt = cnt + CW'(1);
                // Swap data one full cycle after the LEDs go dark to avoid ghosting.
                if (cnt == '0 && !last) begin
                    rgb_nxt   = sel_bits;
                    plane_nxt = plane + PW'(1);
                end
                if (cnt == CW'(BLANK_TICKS - 1)) begin
                    cnt_nxt = '0;
                    if (last) begin
                        state_nxt = IDLE;
                        fd_nxt    = 1'b1;
                    end else begin
                        state_nxt = SHOW;
                        oe_n_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                oe_n_nxt  = 1'b1;
            end
        endcase
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            last_nxt  = 1'b0;
            rgb_nxt   = '0;
            plane_nxt = '0;
            oe_n_nxt  = 1'b1;
            fd_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            word       <= '0;
            last       <= 1'b0;
            rgb_out    <= '0;
            plane      <= '0;
            oe_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            word       <= word_nxt;
            last       <= last_nxt;
            rgb_out    <= rgb_nxt;
            plane      <= plane_nxt;
            oe_n       <= oe_n_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_bitplane_sequencer.sv
// Bench for bitplane_sequencer: a per-cycle expectation queue built from the frame schedule,
// plus directed checks of literal values, run lengths, clear and reset behaviour.
module tb_bitplane_sequencer;

    localparam int DEPTH    = 4;
    localparam int CHANNELS = 2;
    localparam int BASE     = 2;
    localparam int BLANKT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = 24'd0;
    logic        in_ready;
    logic [5:0]  rgb_out;
    logic [1:0]  plane;
    logic        oe_n;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    bitplane_sequencer #(
        .DEPTH       (DEPTH),
        .CHANNELS    (CHANNELS),
        .BASE_TICKS  (BASE),
        .BLANK_TICKS (BLANKT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rgb_out    (rgb_out),
        .plane      (plane),
        .oe_n       (oe_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] plane_bits(input logic [23:0] w, input int p);
        logic [5:0] r;
        r = '0;
        for (int j = 0; j < 6; j++) r[j] = w[j*DEPTH + p];
        return r;
    endfunction

    typedef struct packed {
        logic       oe_n;
        logic [5:0] rgb;
        logic [1:0] plane;
        logic       fd;
        logic       chk;
    } exp_t;

    exp_t q[$];
    exp_t cur = '{oe_n: 1'b1, rgb: 6'd0, plane: 2'd0, fd: 1'b0, chk: 1'b1};
    bit   exp_idle = 1'b1;

    // Schedule of one frame: per plane, SHOW cycles then BLANK cycles; then the done cycle.
    task automatic build_frame(input logic [23:0] w);
        for (int p = 0; p < DEPTH; p++) begin
            for (int t = 0; t < (BASE << p); t++)
                q.push_back('{oe_n: 1'b0, rgb: plane_bits(w, p), plane: 2'(p), fd: 1'b0, chk: 1'b1});
            for (int b = 0; b < BLANKT; b++)
                q.push_back('{oe_n: 1'b1, rgb: plane_bits(w, p), plane: 2'(p), fd: 1'b0, chk: (b == 0)});
        end
        q.push_back('{oe_n: 1'b1, rgb: plane_bits(w, DEPTH-1), plane: 2'(DEPTH-1), fd: 1'b1, chk: 1'b1});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur = '{oe_n: 1'b1, rgb: 6'd0, plane: 2'd0, fd: 1'b0, chk: 1'b1};
        end else if (clear) begin
            q.delete();
            cur = '{oe_n: 1'b1, rgb: 6'd0, plane: 2'd0, fd: 1'b0, chk: 1'b1};
        end else begin
            if (q.size() == 0 && in_valid) build_frame(in_data);
            if (q.size() > 0) cur = q.pop_front();
            else cur = '{oe_n: 1'b1, rgb: cur.rgb, plane: cur.plane, fd: 1'b0, chk: 1'b1};
        end
        exp_idle = (q.size() == 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("oe_n", 32'(oe_n), 32'(cur.oe_n));
            check("frame_done", 32'(frame_done), 32'(cur.fd));
            check("in_ready", 32'(in_ready), 32'(exp_idle && !clear));
            if (cur.chk) begin
                check("rgb_out", 32'(rgb_out), 32'(cur.rgb));
                check("plane", 32'(plane), 32'(cur.plane));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic oe_tr [0:63];
        logic fd_tr [0:63];
        int   bad, k0, nf, fd_at;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_oe_n", 32'(oe_n), 32'd1);
        check("reset_rgb", 32'(rgb_out), 32'd0);
        check("reset_plane", 32'(plane), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed frame; in_data is scrambled every cycle after capture.
        tick;
        in_data = 24'hA5C30F;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            oe_tr[k] = oe_n;
            fd_tr[k] = frame_done;
            if (k == 0) begin
                check("plane0_rgb", 32'(rgb_out), 32'b010101);
                check("plane0_idx", 32'(plane), 32'd0);
            end
            if (k == 20) begin
                check("plane3_rgb", 32'(rgb_out), 32'b101001);
                check("plane3_idx", 32'(plane), 32'd3);
            end
            if (k == 38) check("ready_at_done", 32'(in_ready), 32'd1);
            in_data = 24'($urandom);
        end
        bad = 0;
        k0 = 0;
        for (int p = 0; p < DEPTH; p++) begin
            for (int t = 0; t < (BASE << p); t++) begin
                if (oe_tr[k0] !== 1'b0) bad++;
                k0++;
            end
            for (int t = 0; t < BLANKT; t++) begin
                if (oe_tr[k0] !== 1'b1) bad++;
                k0++;
            end
        end
        check("oe_n_runs", 32'(bad), 32'd0);
        nf = 0;
        fd_at = -1;
        for (int k = 0; k < 42; k++) begin
            if (fd_tr[k] === 1'b1) begin
                nf++;
                if (fd_at < 0) fd_at = k;
            end
        end
        check("frame_done_at", 32'(fd_at), 32'd38);
        check("frame_done_count", 32'(nf), 32'd1);

        // Clear during plane 2 SHOW, then clear together with in_valid.
        tick;
        in_data = 24'($urandom);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (12) tick;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        @(negedge clk);
        check("clear_oe_n", 32'(oe_n), 32'd1);
        check("clear_rgb", 32'(rgb_out), 32'd0);
        check("clear_plane", 32'(plane), 32'd0);
        check("clear_in_ready", 32'(in_ready), 32'd1);
        check("clear_frame_done", 32'(frame_done), 32'd0);
        nf = 0;
        repeat (45) begin
            @(negedge clk);
            if (frame_done) nf++;
        end
        check("no_done_after_clear", 32'(nf), 32'd0);
        tick;
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 24'hFFFFFF;
        tick;
        clear = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("clear_wins_oe_n", 32'(oe_n), 32'd1);
        check("clear_wins_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("clear_wins_oe_n_2", 32'(oe_n), 32'd1);

        // Reset mid-SHOW must darken the LEDs before the next edge.
        tick;
        in_data = 24'($urandom);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        @(negedge clk);
        check("pre_reset_oe_n", 32'(oe_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_oe_n", 32'(oe_n), 32'd1);
        check("async_reset_rgb", 32'(rgb_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(in_ready), 32'd1);
        tick;
        in_data = 24'h123456;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        fd_at = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (frame_done && fd_at < 0) fd_at = k;
        end
        check("recovery_frame_len", 32'(fd_at), 32'd38);

        // Random traffic with occasional clears.
        for (int i = 0; i < 800; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 24'($urandom);
            clear    = ($urandom_range(0, 79) == 0);
            tick;
        end
        clear = 1'b0;
        in_valid = 1'b0;
        repeat (50) tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
